// File: rtl/ofm_accumulation_buffer_pkg.sv
// Shared types and sizing helpers for the output-feature-map accumulation buffer.
package ofm_accumulation_buffer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDrain
    } state_e;

    localparam int unsigned NUM_CHANNELS = 3;

    function automatic int unsigned map_words(input int unsigned side);
        return side * side;
    endfunction

    function automatic int unsigned addr_width(input int unsigned words);
        return (words > 1) ? unsigned'($clog2(words)) : 1;
    endfunction

    // Counters must be able to hold the terminal value MAP_WORDS itself.
    function automatic int unsigned cnt_width(input int unsigned words);
        return unsigned'($clog2(words + 1));
    endfunction

endpackage

// File: rtl/ofm_accumulation_buffer_bank_ram.sv
// One output-map bank: single write port, single registered read port.
module ofm_bank_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 784,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ofm_accumulation_buffer.sv
// Partial-sum buffer: serves/writes back accumulations per bank, then streams all banks out.
module ofm_accumulation_buffer
    import ofm_accumulation_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned IFM_SIZE_NEXT      = 28,
    parameter int unsigned NUMBER_OF_IFM_NEXT = 3,
    parameter int unsigned WB_LATENCY         = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  acc_start,
    input  logic [$clog2(NUMBER_OF_IFM_NEXT)-1:0] filter_sel,
    input  logic                                  first_pass,
    input  logic                                  pixel_valid,
    input  logic [DATA_WIDTH-1:0]                 data_out_for_next,
    output logic [DATA_WIDTH-1:0]                 data_in_from_next,
    output logic                                  pass_done,
    input  logic                                  drain_start,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 data_out_1,
    output logic [DATA_WIDTH-1:0]                 data_out_2,
    output logic [DATA_WIDTH-1:0]                 data_out_3,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int unsigned MapWords = map_words(IFM_SIZE_NEXT);
    localparam int unsigned AddrW    = addr_width(MapWords);
    localparam int unsigned CntW     = cnt_width(MapWords);
    localparam int unsigned SelW     = $clog2(NUMBER_OF_IFM_NEXT);

    localparam logic [CntW-1:0] MapCnt  = CntW'(MapWords);
    localparam logic [CntW-1:0] LastIdx = CntW'(MapWords - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e                state_q, state_d;
    logic [SelW-1:0]       sel_q, sel_d;
    logic                  first_q, first_d;
    logic [CntW-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [CntW-1:0]       d_cnt_q, d_cnt_d;
    logic [WB_LATENCY-1:0] vld_sr_q;
    logic                  rd_zero_q;
    logic [SelW-1:0]       rd_bank_q;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  pass_done_q, pass_done_d;

    logic                  pix_take;
    logic                  wb_fire;
    logic                  drain_load;
    logic                  drain_done;
    logic [AddrW-1:0]      raddr;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_CHANNELS];

    assign pix_take   = (state_q == StAcc) && pixel_valid && (rd_cnt_q < MapCnt);
    assign wb_fire    = (state_q == StAcc) && vld_sr_q[WB_LATENCY-1];
    // The output register reloads when empty or being consumed, until the last word is held.
    assign drain_load = (state_q == StDrain) && (!out_valid_q || out_ready) && !out_last_q;
    assign drain_done = (state_q == StDrain) && out_valid_q && out_ready && out_last_q;
    assign raddr      = (state_q == StDrain) ? d_cnt_q[AddrW-1:0] : rd_cnt_q[AddrW-1:0];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        first_d     = first_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        d_cnt_d     = d_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pass_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (acc_start) begin
                    state_d  = StAcc;
                    sel_d    = filter_sel;
                    first_d  = first_pass;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end else if (drain_start) begin
                    state_d     = StDrain;
                    d_cnt_d     = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            StAcc: begin
                if (pix_take) begin
                    rd_cnt_d = rd_cnt_q + CntOne;
                end
                if (wb_fire) begin
                    wr_cnt_d = wr_cnt_q + CntOne;
                    if (wr_cnt_q == LastIdx) begin
                        pass_done_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (drain_load) begin
                    out_valid_d = 1'b1;
                    out_last_d  = (d_cnt_q == LastIdx);
                    d_cnt_d     = d_cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            first_q     <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            d_cnt_q     <= '0;
            vld_sr_q    <= '0;
            rd_zero_q   <= 1'b0;
            rd_bank_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            first_q     <= first_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            d_cnt_q     <= d_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pass_done_q <= pass_done_d;
            vld_sr_q    <= (state_q == StAcc) ? ((vld_sr_q << 1) | WB_LATENCY'(pix_take)) : '0;
            // Remember which source the current read word came from so it holds until the next read.
            if (pix_take) begin
                rd_zero_q <= first_q;
                rd_bank_q <= sel_q;
            end
        end
    end

    for (genvar b = 0; b < NUM_CHANNELS; b++) begin : g_bank
        logic sel_hit;
        assign sel_hit = (sel_q == SelW'(b));

        ofm_bank_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (MapWords),
            .ADDR_WIDTH(AddrW)
        ) u_ram (
            .clk  (clk),
            .reset(reset),
            .we   (wb_fire && sel_hit && !reset),
            .waddr(wr_cnt_q[AddrW-1:0]),
            .wdata(data_out_for_next),
            .re   ((pix_take && sel_hit) || drain_load),
            .raddr(raddr),
            .rdata(bank_rdata[b])
        );
    end

    always_comb begin
        data_in_from_next = '0;
        if (!rd_zero_q) begin
            for (int b = 0; b < NUM_CHANNELS; b++) begin
                if (rd_bank_q == SelW'(b)) begin
                    data_in_from_next = bank_rdata[b];
                end
            end
        end
    end

    assign data_out_1 = bank_rdata[0];
    assign data_out_2 = bank_rdata[1];
    assign data_out_3 = bank_rdata[2];
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign pass_done  = pass_done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/ofm_accumulation_buffer.md
# ofm_accumulation_buffer

Output-feature-map partial-sum buffer at the output of a convolution datapath.
- Serves stored partial sums on `data_in_from_next` in raster order, aligned with the conv pipeline.
- Writes back the accumulated and activated result from `data_out_for_next` after a fixed latency.
- Once all input-depth slices are accumulated, streams the finished maps to the next layer as three parallel valid/ready channels.

## Interface
Parameters:
- DATA_WIDTH, 32, word width (IEEE-754 single).
- IFM_SIZE_NEXT, 28, output map side length; MAP_WORDS = IFM_SIZE_NEXT*IFM_SIZE_NEXT.
- NUMBER_OF_IFM_NEXT, 3, number of output maps (banks); fixed at 3 to match the three output channels.
- WB_LATENCY, 3, cycles from `pixel_valid` to the matching `data_out_for_next`; must be ≥1 and < MAP_WORDS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- acc_start  in  1  begin one accumulation pass over map `filter_sel`.
- filter_sel  in  $clog2(NUMBER_OF_IFM_NEXT)  target bank, sampled on an accepted `acc_start`.
- first_pass  in  1  sampled on an accepted `acc_start`; 1 means the pass reads zeros instead of memory.
- pixel_valid  in  1  conv datapath presents one output pixel this cycle.
- data_out_for_next  in  DATA_WIDTH  write-back word from the accumulator/relu.
- data_in_from_next  out  DATA_WIDTH  partial sum to the accumulator.
- pass_done  out  1  one-cycle pulse after the last write-back of a pass.
- drain_start  in  1  begin streaming all banks out.
- out_valid  out  1  output word valid.
- out_ready  in  1  next layer accepts the output word.
- data_out_1 / data_out_2 / data_out_3  out  DATA_WIDTH  banks 0/1/2, same address on all three.
- out_last  out  1  marks the word at address MAP_WORDS-1.
- busy  out  1  state ≠ IDLE.

## Operation
FSM states: IDLE, ACC, DRAIN.
- **IDLE**
  - `acc_start` → ACC. Latches `filter_sel` and `first_pass`; clears the read and write counters.
  - Otherwise `drain_start` → DRAIN. If both are asserted in the same cycle, `acc_start` wins.
- **ACC, read side**
  - Each `pixel_valid` while rd_cnt < MAP_WORDS reads bank[sel][rd_cnt] and increments rd_cnt.
  - `pixel_valid` with rd_cnt = MAP_WORDS is ignored.
- **ACC, write side**
  - `pixel_valid` qualified by rd_cnt < MAP_WORDS is delayed WB_LATENCY cycles through a valid shift register.
  - When the delayed valid is high, `data_out_for_next` is written to bank[sel][wr_cnt] and wr_cnt increments.
  - When wr_cnt reaches MAP_WORDS: pulse `pass_done` and go to IDLE.
- **DRAIN**
  - Reads address d_cnt from all three banks in parallel into a one-entry output register.
  - The register reloads when it is empty, or when `out_valid && out_ready` in the same cycle.
  - After the handshake at d_cnt = MAP_WORDS-1 (`out_last` high), go to IDLE.
- `acc_start` / `drain_start` outside IDLE: ignored.
- `pixel_valid` outside ACC: ignored.
- No read-after-write hazard. Addresses are strictly sequential and WB_LATENCY < MAP_WORDS, so a write can never target an address still awaiting its read.
- No arithmetic is done here; words pass through unmodified.

## Timing
- Read latency is 1. `data_in_from_next` is registered and valid the cycle after `pixel_valid`.
  - It shows mem contents, or 0 when `first_pass`.
  - It holds its value between reads.
- Write-back: `data_out_for_next` is sampled exactly WB_LATENCY cycles after its `pixel_valid`.
- `pass_done` is asserted the cycle after the final write.
- A full pass with back-to-back `pixel_valid` takes MAP_WORDS+WB_LATENCY+1 cycles from `acc_start` to `pass_done`.
- DRAIN:
  - First `out_valid` 2 cycles after `drain_start`.
  - One word per cycle while `out_ready` is held.
  - With `out_ready` low, data and `out_last` stay stable and `out_valid` stays high.
- Reset values:
  - State IDLE; all counters 0.
  - `data_in_from_next`, `data_out_1..3` = 0.
  - `out_valid`, `out_last`, `pass_done`, `busy` = 0.
  - Delay shift register cleared.
  - Memory contents are not cleared.
- Reset mid-ACC or mid-DRAIN: abort with no further writes; pending delayed valids are discarded.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, ACC, DRAIN);
  - the MAP_WORDS and address-width localparam functions;
  - the channel count constant 3.
- Sub-module `ofm_bank_ram`: a simple dual-port RAM with one write port and one registered read port, MAP_WORDS × DATA_WIDTH. It is instantiated three times.
- Counters, the delay line and the FSM live in the top module.

## Test plan
Parameters for all scenarios: IFM_SIZE_NEXT=4 (MAP_WORDS=16), WB_LATENCY=3.
- **First pass:** `acc_start`, filter_sel=1, first_pass=1; 16 back-to-back `pixel_valid` with write-back value = index. Expect `data_in_from_next` = 0 ×16 and `pass_done` at cycle 20; bank 1 then holds 0..15.
- **Second pass:** same bank, first_pass=0. Expect `data_in_from_next` = 0..15 in order; write-backs 100+i stored.
- **Gapped `pixel_valid`:** valid every 3rd cycle. Expect write-back to track each pixel at +3 cycles, and exactly 16 writes.
- **Drain:** banks preloaded with 0x3F800000 / 0x40000000 / 0x40400000 (1.0 / 2.0 / 3.0), `out_ready` toggled 1,0,1,…. Expect 16 accepted words with stable hold during stalls, `out_last` only on word 16, then `busy` = 0.
- **Collisions:** `acc_start` and `drain_start` in the same cycle → ACC. `drain_start` during ACC → ignored. Extra `pixel_valid` after 16 → no read, no write.
- **Reset:** `reset` after 7 write-backs. Expect all outputs 0 and IDLE next cycle, no further writes, and addresses 0..6 retaining their new values.
